// File: rtl/mmss_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package mmss_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX       = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_WRAP = 4'd5;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mmss_timer_bcd_down_digit.sv
// One BCD digit of a decrement chain: borrows wrap the digit to wrap_val.
// Latency: combinational. Backpressure: none.
// Flow: borrow_out asserts only when a borrow arrives at a digit that is 0.
module bcd_down_digit
  import mmss_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               borrow_in,
  input  logic [DIGIT_W-1:0] wrap_val,
  output logic [DIGIT_W-1:0] digit_out,
  output logic               borrow_out
);

  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == '0) begin
        digit_out  = wrap_val;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmss_timer.sv
// Keypad-loaded MM:SS countdown timer with ENTRY/RUN/DONE control.
// Latency: digits, running and done update one cycle after the qualifying pgt_1Hz edge.
// Backpressure: none; only rising edges of pgt_1Hz are acted on, levels are ignored.
module mmss_timer
  import mmss_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DIGIT_W-1:0] D,
  input  logic               load,
  input  logic               pgt_1Hz,
  input  logic               en,
  input  logic               clear,
  output logic [DIGIT_W-1:0] mm_tens,
  output logic [DIGIT_W-1:0] mm_ones,
  output logic [DIGIT_W-1:0] ss_tens,
  output logic [DIGIT_W-1:0] ss_ones,
  output logic               zero,
  output logic               running,
  output logic               done
);

  state_t state, state_nxt;
  logic   pgt_q;
  logic   pgt_edge;
  logic   shift_en;
  logic   dec_en;
  logic   done_nxt;
  logic   dec_zero;

  logic [DIGIT_W-1:0] dec_mt, dec_mo, dec_st, dec_so;
  logic               b_so, b_st, b_mo, b_mt;

  assign pgt_edge = pgt_1Hz & ~pgt_q;
  assign zero     = (mm_tens == '0) && (mm_ones == '0) && (ss_tens == '0) && (ss_ones == '0);

  bcd_down_digit u_ss_ones (.digit_in(ss_ones), .borrow_in(1'b1), .wrap_val(BCD_MAX),
                            .digit_out(dec_so), .borrow_out(b_so));
  bcd_down_digit u_ss_tens (.digit_in(ss_tens), .borrow_in(b_so), .wrap_val(SEC_TENS_WRAP),
                            .digit_out(dec_st), .borrow_out(b_st));
  bcd_down_digit u_mm_ones (.digit_in(mm_ones), .borrow_in(b_st), .wrap_val(BCD_MAX),
                            .digit_out(dec_mo), .borrow_out(b_mo));
  bcd_down_digit u_mm_tens (.digit_in(mm_tens), .borrow_in(b_mo), .wrap_val(BCD_MAX),
                            .digit_out(dec_mt), .borrow_out(b_mt));

  assign dec_zero = (dec_mt == '0) && (dec_mo == '0) && (dec_st == '0) && (dec_so == '0);

  // Edges are applied under the current state; reaching 00:00 outranks a pause.
  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    dec_en    = 1'b0;
    done_nxt  = 1'b0;
    if (clear) begin
      state_nxt = ENTRY;
    end else begin
      case (state)
        ENTRY: begin
          shift_en = pgt_edge & load & (D <= BCD_MAX);
          if (en && !zero) state_nxt = RUN;
        end
        RUN: begin
          // A chain underflow (decrement from 00:00) is never committed.
          dec_en = pgt_edge & ~b_mt;
          if (dec_en && dec_zero) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else if (!en) begin
            state_nxt = ENTRY;
          end
        end
        DONE: begin
          if (!en) state_nxt = ENTRY;
        end
        default: state_nxt = ENTRY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ENTRY;
      pgt_q   <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
      mm_tens <= '0;
      mm_ones <= '0;
      ss_tens <= '0;
      ss_ones <= '0;
    end else begin
      state   <= state_nxt;
      pgt_q   <= pgt_1Hz;
      running <= (state_nxt == RUN);
      done    <= done_nxt;
      if (clear) begin
        mm_tens <= '0;
        mm_ones <= '0;
        ss_tens <= '0;
        ss_ones <= '0;
      end else if (shift_en) begin
        mm_tens <= mm_ones;
        mm_ones <= ss_tens;
        ss_tens <= ss_ones;
        ss_ones <= D;
      end else if (dec_en) begin
        mm_tens <= dec_mt;
        mm_ones <= dec_mo;
        ss_tens <= dec_st;
        ss_ones <= dec_so;
      end
    end
  end

endmodule

// File: tb/tb_mmss_timer.sv
// Directed scenarios plus random stimulus checked every cycle against a
// time-as-integer reference model of the MM:SS countdown timer.
module tb_mmss_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D;
  logic       load, pgt_1Hz, en, clear;
  logic [3:0] mm_tens, mm_ones, ss_tens, ss_ones;
  logic       zero, running, done;

  always #5 clk = ~clk;

  mmss_timer dut (
    .clk(clk), .rst_n(rst_n), .D(D), .load(load), .pgt_1Hz(pgt_1Hz), .en(en),
    .clear(clear), .mm_tens(mm_tens), .mm_ones(mm_ones), .ss_tens(ss_tens),
    .ss_ones(ss_ones), .zero(zero), .running(running), .done(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: time held as a 4-digit decimal number MMSS.
  localparam int M_ENTRY = 0, M_RUN = 1, M_DONE = 2;
  int m_n;
  int m_st;
  bit m_pq;
  bit m_done;
  bit cur_en;

  function automatic int dec_time(input int n);
    int m, s;
    m = n / 100;
    s = n % 100;
    if (s > 0) s = s - 1;
    else begin
      s = 59;
      m = m - 1;
    end
    return m * 100 + s;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic model_reset();
    m_n = 0; m_st = M_ENTRY; m_pq = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit e;
    int old_n;
    e = pgt_1Hz & ~m_pq;
    m_pq = pgt_1Hz;
    m_done = 0;
    old_n = m_n;
    if (clear) begin
      m_n = 0;
      m_st = M_ENTRY;
    end else begin
      case (m_st)
        M_ENTRY: begin
          if (e && load && D <= 9) m_n = (m_n * 10 + int'(D)) % 10000;
          if (en && old_n != 0) m_st = M_RUN;
        end
        M_RUN: begin
          if (e) m_n = dec_time(m_n);
          if (e && m_n == 0) begin
            m_st = M_DONE;
            m_done = 1;
          end else if (!en) m_st = M_ENTRY;
        end
        default: if (!en) m_st = M_ENTRY;
      endcase
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_time"}, {16'h0, mm_tens, mm_ones, ss_tens, ss_ones}, {16'h0, to_bcd(m_n)});
    check({tag, "_zero"}, 32'(zero), 32'(m_n == 0));
    check({tag, "_run"},  32'(running), 32'(m_st == M_RUN));
    check({tag, "_done"}, 32'(done), 32'(m_done));
  endtask

  task automatic cyc(input bit p, input bit ld, input logic [3:0] d, input bit c, input string tag);
    pgt_1Hz = p; load = ld; D = d; en = cur_en; clear = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic key(input logic [3:0] d);
    cyc(1, 1, d, 0, "key");
    cyc(0, 0, 4'h0, 0, "key_rel");
  endtask

  task automatic tick();
    cyc(1, 0, 4'h0, 0, "tick");
    cyc(0, 0, 4'h0, 0, "tick_low");
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 4'h0, 0, "idle");
  endtask

  function automatic logic [31:0] digits();
    return {16'h0, mm_tens, mm_ones, ss_tens, ss_ones};
  endfunction

  initial begin
    rst_n = 1'b0; D = 4'h0; load = 0; pgt_1Hz = 0; en = 0; clear = 0; cur_en = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_time", digits(), 32'h0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;

    // Keypad entry 1,3,0 -> 01:30
    key(4'd1); key(4'd3); key(4'd0);
    check("k130", digits(), 32'h0130);
    check("k130_zero", 32'(zero), 32'd0);

    // Countdown with minute borrow
    cur_en = 1; idle(1);
    check("start_running", 32'(running), 32'd1);
    for (int i = 0; i < 30; i++) tick();
    check("cd_0100", digits(), 32'h0100);
    tick();
    check("cd_0059", digits(), 32'h0059);

    // 00:02 -> 00:00 with a single-cycle done pulse
    cur_en = 0; idle(1); cyc(0, 0, 4'h0, 1, "clr");
    key(4'd0); key(4'd2);
    cur_en = 1; idle(1);
    tick();
    cyc(1, 0, 4'h0, 0, "final_tick");
    check("done_pulse", 32'(done), 32'd1);
    cyc(0, 0, 4'h0, 0, "after_done");
    check("done_drop", 32'(done), 32'd0);
    tick(); tick();
    check("done_hold", digits(), 32'h0);
    check("done_notrun", 32'(running), 32'd0);
    cur_en = 0; idle(1);

    // Unnormalised seconds and pause/resume entry
    key(4'd9); key(4'd9);
    cur_en = 1; idle(1);
    tick();
    check("cd_0098", digits(), 32'h0098);
    tick(); tick();
    cur_en = 0; idle(1);
    check("pause_0096", digits(), 32'h0096);
    key(4'd5);
    check("resume_0965", digits(), 32'h0965);

    // Start on 00:00 is ignored; clear during RUN
    cyc(0, 0, 4'h0, 1, "clr");
    cur_en = 1; idle(2);
    check("start_zero", 32'(running), 32'd0);
    cur_en = 0; idle(1);
    key(4'd5); key(4'd0); key(4'd0);
    cur_en = 1; idle(1);
    cyc(0, 0, 4'h0, 1, "clr_run");
    check("clr_run_time", digits(), 32'h0);
    check("clr_run_done", 32'(done), 32'd0);
    idle(1);
    check("clr_run_state", 32'(running), 32'd0);

    // Async reset mid-countdown
    cur_en = 0; idle(1);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    cur_en = 1; idle(1);
    pgt_1Hz = 1; load = 0; en = 1;
    #2 rst_n = 1'b0;
    #1;
    check("arst_time", digits(), 32'h0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_running", 32'(running), 32'd0);
    model_reset();
    @(negedge clk);
    pgt_1Hz = 0; en = 0; cur_en = 0;
    rst_n = 1'b1;
    cyc(1, 1, 4'hA, 0, "bad_key");
    check("bad_key_ignored", digits(), 32'h0);
    cyc(0, 0, 4'h0, 0, "bad_key_rel");

    // Random stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cur_en = ~cur_en;
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          $urandom_range(0, 99) == 0, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
